dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Two-requester arbiter that shares the single data-memory port of the MMU between the CPU load/store unit (requester 0) and a debug/DMA master (requester 1). It grants at most one access per cycle, forwards the winner's request to the MMU in the same cycle, tracks read ownership across the MMU's one-clock access latency, and returns read data with a per-requester valid pulse. It also provides bus locking for atomic read-modify-write sequences and a starvation guard for requester 1.

## Interface
- STARVE_LIMIT, 4: consecutive denied cycles after which requester 1 gains priority (1..15).
- LOCK_MAX, 16: maximum cycles a lock is held before forced release (1..255).
- clk  in  1  clock, rising edge
- resetb  in  1  asynchronous reset, active low
- req0 / req1  in  1  access request
- we0 / we1  in  1  write (1) / read (0)
- addr0 / addr1  in  32  byte address
- wdata0 / wdata1  in  32  write data, right-aligned as the MMU expects
- be0 / be1  in  4  byte enable (MMU-legal patterns only)
- sgn0 / sgn1  in  1  sign-extend read
- lock0 / lock1  in  1  hold the port after this grant
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for that requester
- rdata  out  32  read data, shared by both requesters
- lock_err  out  1  one-cycle pulse on forced lock release
- mmu_dm_addr  out  32, mmu_dm_di  out  32, mmu_dm_be  out  4, mmu_dm_we  out  1, mmu_is_signed  out  1  to the MMU
- mmu_dm_do  in  32  from the MMU

## Operation
- States: ARB, LOCK0, LOCK1.
- ARB arbitration:
  - req1 wins if starve_cnt == STARVE_LIMIT.
  - Otherwise req0 wins over req1.
  - Otherwise the single requester wins.
- LOCKn: only requester n may be granted. The other requester's gnt is 0 regardless of its req.
- Transitions:
  - ARB→LOCKn when gntn && lockn.
  - LOCKn→ARB when !lockn is seen at an edge, or when lock_cnt reaches LOCK_MAX−1.
  - A forced release pulses lock_err for one cycle and returns to ARB even if lockn is still high.
- Arbitration in the cycle after the exit edge is normal ARB.
- lock_cnt is cleared on entry to LOCKn and increments each cycle in LOCKn.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each cycle with req1 && !gnt1, in any state.
  - Clears on gnt1.
- MMU side:
  - With a grant, the mmu_dm_* fields are the winner's fields.
  - With no grant, mmu_dm_be=0, mmu_dm_we=0, mmu_dm_addr=0, mmu_dm_di=0, mmu_is_signed=0.
- Read tracking:
  - rd_owner (2 bits) is registered each edge as {gnt1&!we1, gnt0&!we0}.
  - rvalidn = rd_owner[n].
  - rdata = mmu_dm_do when any rvalid is high, else 0.
- Writes complete at the grant edge. No rvalid is generated for writes.

## Timing
- Grant latency: 0 cycles. gnt and mmu_dm_* are combinational from req and state in cycle T.
- Read data is valid in cycle T+1, with rvalid registered at the T edge.
- Throughput: one access per cycle. Back-to-back reads from alternating requesters return in order, one per cycle.
- Reset values while resetb=0: gnt0=gnt1=0; rvalid0=rvalid1=0; lock_err=0; rdata=0; mmu_dm_be=0; mmu_dm_we=0; mmu_dm_addr=0; state=ARB; starve_cnt=0; lock_cnt=0.
- Reset asserted mid-read clears rd_owner. The in-flight read is dropped and no rvalid is produced after release.
- Simultaneous req0 and req1 with starve_cnt < STARVE_LIMIT: gnt0=1, gnt1=0.
- Lock asserted on a write grant is honoured the same as on a read grant.

## Structure
- Shared package dm_arb_pkg holds:
  - state encoding: ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2;
  - requester IDs: REQ_CPU=0, REQ_DBG=1;
  - the MMU idle-request constants.
- One natural sub-module: dm_req_mux, a combinational 2:1 mux of the {addr, di, be, we, sgn} bundle driven by the one-hot grant, with zero output when idle.
- The FSM, counters and rd_owner register live in dm_port_arbiter.

## Test plan
- **Single read.** req0=1, we0=0, addr0=0x10000010, be0=4'b1111; MMU returns 0xDEADBEEF. Expect gnt0=1 in T; rvalid0=1 and rdata=0xDEADBEEF in T+1; rvalid1=0.
- **Contention.** req0 and req1 held for 6 cycles, STARVE_LIMIT=4. Expect gnt0 in cycles 0–3, gnt1 in cycle 4, gnt0 in cycle 5, with starve_cnt clearing after cycle 4.
- **Lock.** Grant req1 with lock1=1 for 3 cycles while req0 is also requesting. Expect gnt0=0 throughout the lock, and gnt0=1 in the first cycle after the edge that sees lock1=0.
- **Lock timeout.** LOCK_MAX=16, lock0 held high. Expect lock_err to pulse once at cycle 16, the state to return to ARB, and req1 to be granted next.
- **Write then read.** req0 write 0x000000AB with be=4'b0001, then a read. Expect no rvalid after the write and rvalid0 exactly one cycle after the read grant.
- **Reset mid-read.** Deassert resetb in the cycle after a read grant. Expect rvalid0=0 immediately, and all outputs to hold their reset values until release.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory port arbiter:
//   - arb_state_e : arbiter FSM encoding (ARB / LOCK0 / LOCK1)
//   - REQ_CPU/DBG : requester indices into the one-hot grant vector
//   - dm_req_t    : the request bundle forwarded to the MMU
//   - MMU_IDLE_REQ: value driven to the MMU when nothing is granted
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int REQ_CPU = 0;  // load/store unit
  localparam int REQ_DBG = 1;  // debug / DMA master

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] di;
    logic [3:0]  be;
    logic        we;
    logic        sgn;
  } dm_req_t;

  // An idle MMU cycle: no byte enables, no write, zero address/data.
  localparam dm_req_t MMU_IDLE_REQ = '0;

endpackage

// File: rtl/dm_req_mux.sv
// -----------------------------------------------------------------------------
// dm_req_mux
// Combinational 2:1 selector of the MMU request bundle, steered by the
// one-hot grant. With no grant the MMU sees the idle request (all zero).
//   i_gnt  : one-hot grant, bit REQ_CPU / REQ_DBG
//   i_req0 : requester 0 bundle
//   i_req1 : requester 1 bundle
//   o_req  : bundle presented to the MMU
// -----------------------------------------------------------------------------
module dm_req_mux
  import dm_arb_pkg::*;
(
  input  logic [1:0] i_gnt,
  input  dm_req_t    i_req0,
  input  dm_req_t    i_req1,
  output dm_req_t    o_req
);

  always_comb begin
    // NOTE: default assigned first so every path drives o_req; no latch.
    o_req = MMU_IDLE_REQ;
    if (i_gnt[REQ_CPU]) begin
      o_req = i_req0;
    end else if (i_gnt[REQ_DBG]) begin
      o_req = i_req1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
// Shares the MMU data-memory port between the CPU load/store unit (req 0)
// and a debug/DMA master (req 1). Grants are combinational (zero latency),
// read ownership is registered across the MMU's one-clock latency, and a
// bus lock with timeout plus a starvation guard for requester 1 are provided.
// Ports:
//   clk, resetb                      : clock, async active-low reset
//   reqN/weN/addrN/wdataN/beN/sgnN   : requester N access
//   lockN                            : hold the port after this grant
//   gntN                             : accepted this cycle (combinational)
//   rvalidN, rdata                   : read return (rdata shared)
//   lock_err                         : pulse on forced lock release
//   mmu_dm_*, mmu_is_signed          : request to the MMU
//   mmu_dm_do                        : read data from the MMU
// -----------------------------------------------------------------------------
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  input  logic        sgn0,
  input  logic        sgn1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        lock_err,
  output logic [31:0] mmu_dm_addr,
  output logic [31:0] mmu_dm_di,
  output logic [3:0]  mmu_dm_be,
  output logic        mmu_dm_we,
  output logic        mmu_is_signed,
  input  logic [31:0] mmu_dm_do
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [7:0]  r_lock_cnt;
  logic [1:0]  r_rd_owner;
  logic [1:0]  w_gnt_raw;
  logic [1:0]  w_gnt;
  logic        w_lock_err;
  logic        w_starved;
  logic        w_timeout;
  dm_req_t     w_req0;
  dm_req_t     w_req1;
  dm_req_t     w_mmu_req;

  assign w_starved = (r_starve_cnt == STARVE_MAX);
  assign w_timeout = (r_lock_cnt == LOCK_LAST);

  always_comb begin
    w_gnt_raw   = 2'b00;
    w_state_nxt = r_state;
    w_lock_err  = 1'b0;
    unique case (r_state)
      ARB: begin
        if (req1 && w_starved)  w_gnt_raw[REQ_DBG] = 1'b1;
        else if (req0)          w_gnt_raw[REQ_CPU] = 1'b1;
        else if (req1)          w_gnt_raw[REQ_DBG] = 1'b1;
        if (w_gnt_raw[REQ_CPU] && lock0)      w_state_nxt = LOCK0;
        else if (w_gnt_raw[REQ_DBG] && lock1) w_state_nxt = LOCK1;
      end
      LOCK0: begin
        w_gnt_raw[REQ_CPU] = req0;
        if (!lock0 || w_timeout) w_state_nxt = ARB;
        // Only a timeout with the lock still requested is an error.
        w_lock_err = lock0 && w_timeout;
      end
      LOCK1: begin
        w_gnt_raw[REQ_DBG] = req1;
        if (!lock1 || w_timeout) w_state_nxt = ARB;
        w_lock_err = lock1 && w_timeout;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Grants are combinational, so they must also be masked while in reset.
  assign w_gnt = w_gnt_raw & {2{resetb}};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state      <= ARB;
      r_starve_cnt <= '0;
      r_lock_cnt   <= '0;
      r_rd_owner   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      if (w_gnt[REQ_DBG]) begin
        r_starve_cnt <= '0;
      end else if (req1 && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      // Cleared on any state change (entry and exit); counts while locked.
      if (w_state_nxt != r_state) begin
        r_lock_cnt <= '0;
      end else if (r_state != ARB) begin
        r_lock_cnt <= r_lock_cnt + 8'd1;
      end
      r_rd_owner <= {w_gnt[REQ_DBG] & ~we1, w_gnt[REQ_CPU] & ~we0};
    end
  end

  assign w_req0 = '{addr: addr0, di: wdata0, be: be0, we: we0, sgn: sgn0};
  assign w_req1 = '{addr: addr1, di: wdata1, be: be1, we: we1, sgn: sgn1};

  dm_req_mux u_req_mux (
    .i_gnt  (w_gnt),
    .i_req0 (w_req0),
    .i_req1 (w_req1),
    .o_req  (w_mmu_req)
  );

  assign gnt0          = w_gnt[REQ_CPU];
  assign gnt1          = w_gnt[REQ_DBG];
  assign rvalid0       = r_rd_owner[REQ_CPU];
  assign rvalid1       = r_rd_owner[REQ_DBG];
  assign rdata         = (|r_rd_owner) ? mmu_dm_do : 32'd0;
  assign lock_err      = w_lock_err;
  assign mmu_dm_addr   = w_mmu_req.addr;
  assign mmu_dm_di     = w_mmu_req.di;
  assign mmu_dm_be     = w_mmu_req.be;
  assign mmu_dm_we     = w_mmu_req.we;
  assign mmu_is_signed = w_mmu_req.sgn;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
// Directed bench for dm_port_arbiter (STARVE_LIMIT=4, LOCK_MAX=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        resetb;
  logic        req0, req1, we0, we1, sgn0, sgn1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1, lock_err;
  logic [31:0] rdata, mmu_dm_addr, mmu_dm_di, mmu_dm_do;
  logic [3:0]  mmu_dm_be;
  logic        mmu_dm_we, mmu_is_signed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(16)) dut (
    .clk(clk), .resetb(resetb),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .sgn0(sgn0), .sgn1(sgn1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .lock_err(lock_err),
    .mmu_dm_addr(mmu_dm_addr), .mmu_dm_di(mmu_dm_di), .mmu_dm_be(mmu_dm_be),
    .mmu_dm_we(mmu_dm_we), .mmu_is_signed(mmu_is_signed),
    .mmu_dm_do(mmu_dm_do)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; sgn0 = 0; sgn1 = 0;
    lock0 = 0; lock1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    be0 = '0; be1 = '0; mmu_dm_do = '0;
  endtask

  task automatic test_reset();
    resetb = 0;
    idle_inputs();
    req0 = 1; req1 = 1; addr0 = 32'h0000_1234; addr1 = 32'h0000_5678;
    be0 = 4'hF; be1 = 4'hF; we0 = 1; mmu_dm_do = 32'hFFFF_FFFF;
    repeat (2) step();
    #1;
    n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
    n_tests++; if ({rvalid0, rvalid1, lock_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {rvalid0, rvalid1, lock_err}); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_tests++; if ({mmu_dm_be, mmu_dm_we} !== 5'b0) begin n_fail++; $display("FAIL reset_mmu_be_we got=%b exp=0", {mmu_dm_be, mmu_dm_we}); end
    n_tests++; if (mmu_dm_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mmu_addr got=%h exp=0", mmu_dm_addr); end
    idle_inputs();
    step();
    resetb = 1;
    step();
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 32'h1000_0010; be0 = 4'b1111; sgn0 = 1;
    #1;
    n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt got=%b exp=10", {gnt0, gnt1}); end
    n_tests++; if (mmu_dm_addr !== 32'h1000_0010) begin n_fail++; $display("FAIL rd_addr got=%h exp=10000010", mmu_dm_addr); end
    n_tests++; if ({mmu_dm_be, mmu_dm_we, mmu_is_signed} !== 6'b1111_0_1) begin n_fail++; $display("FAIL rd_be_we_sgn got=%b exp=111101", {mmu_dm_be, mmu_dm_we, mmu_is_signed}); end
    step();
    idle_inputs();
    mmu_dm_do = 32'hDEAD_BEEF;
    #1;
    n_tests++; if ({rvalid0, rvalid1} !== 2'b10) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=10", {rvalid0, rvalid1}); end
    n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdata); end
    n_tests++; if ({mmu_dm_be, mmu_dm_addr} !== 36'h0) begin n_fail++; $display("FAIL rd_idle_mmu got=%h exp=0", {mmu_dm_be, mmu_dm_addr}); end
    step();
    #1;
    n_tests++; if ({rvalid0, rdata} !== 33'h0) begin n_fail++; $display("FAIL rd_after got=%h exp=0", {rvalid0, rdata}); end
  endtask

  // Both held for 6 cycles: gnt0 in 0..3, gnt1 in 4, gnt0 in 5.
  task automatic test_contention();
    logic [5:0] exp_g1;
    logic [5:0] exp_rv1;
    exp_g1  = 6'b01_0000;  // bit i = cycle i
    exp_rv1 = 6'b10_0000;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; be0 = 4'hF; be1 = 4'hF;
    addr0 = 32'h0000_0100; addr1 = 32'h0000_0200;
    for (int i = 0; i < 6; i++) begin
      mmu_dm_do = 32'hA000_0000 + 32'(i);
      #1;
      n_tests++; if ({gnt0, gnt1} !== {~exp_g1[i], exp_g1[i]}) begin n_fail++; $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, {gnt0, gnt1}, {~exp_g1[i], exp_g1[i]}); end
      n_tests++; if (mmu_dm_addr !== (exp_g1[i] ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL cont_addr[%0d] got=%h", i, mmu_dm_addr); end
      if (i > 0) begin
        n_tests++; if ({rvalid0, rvalid1} !== {~exp_rv1[i], exp_rv1[i]}) begin n_fail++; $display("FAIL cont_rvalid[%0d] got=%b exp=%b", i, {rvalid0, rvalid1}, {~exp_rv1[i], exp_rv1[i]}); end
        n_tests++; if (rdata !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL cont_rdata[%0d] got=%h exp=%h", i, rdata, 32'hA000_0000 + 32'(i)); end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lock();
    req1 = 1; lock1 = 1; we1 = 0; be1 = 4'hF; addr1 = 32'h0000_0300;
    #1;
    n_tests++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL lock_grant got=%b exp=01", {gnt0, gnt1}); end
    step();
    req0 = 1; be0 = 4'hF; addr0 = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      lock1 = (i < 2);
      #1;
      n_tests++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL lock_hold[%0d] got=%b exp=01", i, {gnt0, gnt1}); end
      n_tests++; if (mmu_dm_addr !== 32'h300) begin n_fail++; $display("FAIL lock_addr[%0d] got=%h exp=300", i, mmu_dm_addr); end
      step();
    end
    #1;
    n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL lock_release got=%b exp=10", {gnt0, gnt1}); end
    idle_inputs();
    step();
  endtask

  // Grant in cycle 0, lock cycles 1..16, forced release ends cycle 16.
  task automatic test_lock_timeout();
    req0 = 1; lock0 = 1; we0 = 1; be0 = 4'hF; addr0 = 32'h0000_0500;
    req1 = 1; we1 = 0; be1 = 4'hF; addr1 = 32'h0000_0600;
    #1;
    n_tests++; if ({gnt0, gnt1, lock_err} !== 3'b100) begin n_fail++; $display("FAIL to_grant got=%b exp=100", {gnt0, gnt1, lock_err}); end
    step();
    for (int k = 1; k <= 16; k++) begin
      #1;
      n_tests++; if ({gnt0, gnt1, lock_err} !== {2'b10, (k == 16)}) begin n_fail++; $display("FAIL to_cycle[%0d] got=%b exp=%b", k, {gnt0, gnt1, lock_err}, {2'b10, (k == 16)}); end
      step();
    end
    #1;
    n_tests++; if ({gnt0, gnt1, lock_err} !== 3'b010) begin n_fail++; $display("FAIL to_after got=%b exp=010", {gnt0, gnt1, lock_err}); end
    n_tests++; if (mmu_dm_addr !== 32'h600) begin n_fail++; $display("FAIL to_after_addr got=%h exp=600", mmu_dm_addr); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_write_then_read();
    req0 = 1; we0 = 1; addr0 = 32'h0000_0020; wdata0 = 32'h0000_00AB; be0 = 4'b0001;
    #1;
    n_tests++; if ({gnt0, mmu_dm_we, mmu_dm_be} !== 6'b1_1_0001) begin n_fail++; $display("FAIL wr_req got=%b exp=110001", {gnt0, mmu_dm_we, mmu_dm_be}); end
    n_tests++; if (mmu_dm_di !== 32'h0000_00AB) begin n_fail++; $display("FAIL wr_data got=%h exp=000000ab", mmu_dm_di); end
    step();
    we0 = 0; addr0 = 32'h0000_0024; be0 = 4'hF; wdata0 = '0; mmu_dm_do = 32'h1111_2222;
    #1;
    n_tests++; if ({rvalid0, rvalid1, rdata} !== 34'h0) begin n_fail++; $display("FAIL wr_no_rvalid got=%b%b rdata=%h exp=0", rvalid0, rvalid1, rdata); end
    n_tests++; if ({gnt0, mmu_dm_we} !== 2'b10) begin n_fail++; $display("FAIL wr_rd_gnt got=%b exp=10", {gnt0, mmu_dm_we}); end
    step();
    idle_inputs();
    mmu_dm_do = 32'h0000_0055;
    #1;
    n_tests++; if ({rvalid0, rdata} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL wr_rd_rvalid got=%b rdata=%h exp=1/55", rvalid0, rdata); end
    step();
    #1;
    n_tests++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL wr_rd_single got=%b exp=0", rvalid0); end
  endtask

  task automatic test_reset_mid_read();
    req0 = 1; we0 = 0; addr0 = 32'h0000_0040; be0 = 4'hF;
    step();
    mmu_dm_do = 32'hCAFE_F00D;
    resetb = 0;
    #1;
    n_tests++; if ({rvalid0, rdata} !== 33'h0) begin n_fail++; $display("FAIL rst_mid_rvalid got=%b rdata=%h exp=0", rvalid0, rdata); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if ({gnt0, gnt1, rvalid0, rvalid1, lock_err, mmu_dm_be, mmu_dm_we} !== 10'h0) begin n_fail++; $display("FAIL rst_mid_hold[%0d] got=%b exp=0", i, {gnt0, gnt1, rvalid0, rvalid1, lock_err, mmu_dm_be, mmu_dm_we}); end
      n_tests++; if ({rdata, mmu_dm_addr} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_bus[%0d] got=%h exp=0", i, {rdata, mmu_dm_addr}); end
    end
    idle_inputs();
    mmu_dm_do = 32'hCAFE_F00D;
    resetb = 1;
    step();
    n_tests++; if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_post got=%b exp=00", {rvalid0, rvalid1}); end
    req1 = 1; addr1 = 32'h0000_0080; be1 = 4'hF;
    #1;
    n_tests++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_arb got=%b exp=01", {gnt0, gnt1}); end
    idle_inputs();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_lock_timeout();
    test_write_then_read();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
